// File: rtl/riscv_core_branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Zero-latency combinational lookup on the fetch PC; trained by the EX-stage resolved outcome.
module riscv_core_branch_predictor #(
    parameter int unsigned ALEN    = 32,
    parameter int unsigned ENTRIES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [ALEN-1:0] i_if_pc,
    output logic            o_valid,
    output logic            o_taken,
    output logic [ALEN-1:0] o_target,
    input  logic            i_upd_en,
    input  logic [ALEN-1:0] i_upd_pc,
    input  logic            i_upd_branch,
    input  logic            i_upd_jump,
    input  logic            i_upd_taken,
    input  logic [ALEN-1:0] i_upd_target
);

    localparam int unsigned INDEX_BITS = $clog2(ENTRIES);
    localparam int unsigned TAG_BITS   = ALEN - INDEX_BITS - 1;

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [ALEN-1:0]     r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];
    logic                r_jump   [ENTRIES];

    logic [INDEX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0]   w_if_tag;
    logic                  w_if_hit;

    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]   w_upd_tag;
    logic                  w_upd_hit;
    logic                  w_wr_en;
    logic [ALEN-1:0]       w_wr_target;
    logic [1:0]            w_wr_ctr;
    logic                  w_wr_jump;

    // PCs are halfword aligned, so bit 0 never selects anything
    logic w_unused;
    assign w_unused = i_if_pc[0] ^ i_upd_pc[0];

    // Lookup: no bypass from a same-cycle update
    assign w_if_idx = i_if_pc[INDEX_BITS:1];
    assign w_if_tag = i_if_pc[ALEN-1:INDEX_BITS+1];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    assign o_valid  = w_if_hit;
    assign o_taken  = w_if_hit && (r_jump[w_if_idx] || r_ctr[w_if_idx][1]);
    assign o_target = w_if_hit ? r_target[w_if_idx] : '0;

    assign w_upd_idx = i_upd_pc[INDEX_BITS:1];
    assign w_upd_tag = i_upd_pc[ALEN-1:INDEX_BITS+1];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    // Training decision; an update flagged as both or neither kind is dropped
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_target = r_target[w_upd_idx];
        w_wr_ctr    = r_ctr[w_upd_idx];
        w_wr_jump   = r_jump[w_upd_idx];
        if (i_upd_en && (i_upd_branch ^ i_upd_jump)) begin
            if (i_upd_jump) begin
                w_wr_en     = 1'b1;
                w_wr_target = i_upd_target;
                w_wr_jump   = 1'b1;
                w_wr_ctr    = 2'b11;
            end else if (w_upd_hit && !r_jump[w_upd_idx]) begin
                w_wr_en = 1'b1;
                if (i_upd_taken) begin
                    w_wr_target = i_upd_target;
                    w_wr_ctr    = (r_ctr[w_upd_idx] == 2'b11) ? 2'b11 : r_ctr[w_upd_idx] + 2'd1;
                end else begin
                    w_wr_ctr    = (r_ctr[w_upd_idx] == 2'b00) ? 2'b00 : r_ctr[w_upd_idx] - 2'd1;
                end
            end else if (w_upd_hit) begin
                w_wr_en     = 1'b1;
                w_wr_jump   = 1'b0;
                w_wr_target = i_upd_target;
                w_wr_ctr    = i_upd_taken ? 2'b10 : 2'b01;
            end else if (i_upd_taken) begin
                w_wr_en     = 1'b1;
                w_wr_jump   = 1'b0;
                w_wr_target = i_upd_target;
                w_wr_ctr    = 2'b10;
            end
        end
    end

    // Table storage; reset wins over a coincident update
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
                r_jump[i]   <= 1'b0;
            end
        end else if (w_wr_en) begin
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= w_wr_target;
            r_ctr[w_upd_idx]    <= w_wr_ctr;
            r_jump[w_upd_idx]   <= w_wr_jump;
        end
    end

endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// Bench for riscv_core_branch_predictor: directed vector table, reset corner case,
// then randomized training checked against a behavioural BTB model.
module tb_riscv_core_branch_predictor;

    localparam int unsigned ALEN       = 32;
    localparam int unsigned ENTRIES    = 16;
    localparam int unsigned INDEX_BITS = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [ALEN-1:0] if_pc;
    logic            o_valid, o_taken;
    logic [ALEN-1:0] o_target;
    logic            upd_en, upd_branch, upd_jump, upd_taken;
    logic [ALEN-1:0] upd_pc, upd_target;

    always #5 clk = ~clk;

    riscv_core_branch_predictor #(.ALEN(ALEN), .ENTRIES(ENTRIES)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_if_pc      (if_pc),
        .o_valid      (o_valid),
        .o_taken      (o_taken),
        .o_target     (o_target),
        .i_upd_en     (upd_en),
        .i_upd_pc     (upd_pc),
        .i_upd_branch (upd_branch),
        .i_upd_jump   (upd_jump),
        .i_upd_taken  (upd_taken),
        .i_upd_target (upd_target)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: one record per index, counter kept as an integer 0..3
    bit              m_valid  [ENTRIES];
    int unsigned     m_tag    [ENTRIES];
    logic [ALEN-1:0] m_target [ENTRIES];
    int              m_ctr    [ENTRIES];
    bit              m_jump   [ENTRIES];

    function automatic void model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 1; m_jump[i] = 0;
        end
    endfunction

    function automatic void model_lookup(input logic [ALEN-1:0] pc, output bit v, output bit t,
                                         output logic [ALEN-1:0] tg);
        int idx = int'((pc / 2) % ENTRIES);
        int unsigned tag = pc / (2 * ENTRIES);
        v  = m_valid[idx] && (m_tag[idx] == tag);
        t  = v && (m_jump[idx] || m_ctr[idx] >= 2);
        tg = v ? m_target[idx] : '0;
    endfunction

    function automatic void model_update(input bit en, input bit br, input bit jp, input bit tk,
                                         input logic [ALEN-1:0] pc, input logic [ALEN-1:0] tgt);
        int idx = int'((pc / 2) % ENTRIES);
        int unsigned tag = pc / (2 * ENTRIES);
        bit hit = m_valid[idx] && (m_tag[idx] == tag);
        if (!en || (br == jp)) return;
        if (jp) begin
            m_valid[idx] = 1; m_tag[idx] = tag; m_target[idx] = tgt; m_jump[idx] = 1; m_ctr[idx] = 3;
        end else if (hit && !m_jump[idx]) begin
            if (tk) begin
                m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
                m_target[idx] = tgt;
            end else begin
                m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
            end
        end else if (hit) begin
            m_jump[idx] = 0; m_target[idx] = tgt; m_ctr[idx] = tk ? 2 : 1;
        end else if (tk) begin
            m_valid[idx] = 1; m_tag[idx] = tag; m_target[idx] = tgt; m_jump[idx] = 0; m_ctr[idx] = 2;
        end
    endfunction

    // Drive one cycle, check the lookup before the edge, then advance the model across the edge
    task automatic run_cycle(input bit rn, input bit en, input bit br, input bit jp, input bit tk,
                             input logic [ALEN-1:0] upc, input logic [ALEN-1:0] utg,
                             input logic [ALEN-1:0] lpc, input bit ev, input bit et,
                             input logic [ALEN-1:0] etg, input string name);
        rst_n = rn; upd_en = en; upd_branch = br; upd_jump = jp; upd_taken = tk;
        upd_pc = upc; upd_target = utg; if_pc = lpc;
        #2;
        checks++;
        if (o_valid !== ev || o_taken !== et || o_target !== etg) begin
            errors++;
            $display("FAIL %s pc=%h got valid=%b taken=%b target=%h expected valid=%b taken=%b target=%h",
                     name, lpc, o_valid, o_taken, o_target, ev, et, etg);
        end
        @(posedge clk);
        if (!rn) model_reset();
        else model_update(en, br, jp, tk, upc, utg);
        #1;
    endtask

    typedef struct {
        bit              en, br, jp, tk;
        logic [ALEN-1:0] upc, utg, lpc;
        bit              ev, et;
        logic [ALEN-1:0] etg;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit              ev, et;
        logic [ALEN-1:0] etg, upc, lpc;
        bit              rn, en, jp;

        // Lookup checked each row reflects the table before that row's update
        vecs.push_back('{0,0,0,0, 32'h000, 32'h000,  32'h100, 0,0,32'h0});
        vecs.push_back('{1,1,0,1, 32'h100, 32'h080,  32'h100, 0,0,32'h0});
        vecs.push_back('{1,1,0,0, 32'h100, 32'h0,    32'h100, 1,1,32'h80});
        vecs.push_back('{1,1,0,0, 32'h100, 32'h0,    32'h100, 1,0,32'h80});
        vecs.push_back('{1,1,0,1, 32'h100, 32'h080,  32'h100, 1,0,32'h80});
        vecs.push_back('{1,1,0,1, 32'h100, 32'h080,  32'h100, 1,0,32'h80});
        vecs.push_back('{1,1,0,1, 32'h100, 32'h080,  32'h100, 1,1,32'h80});
        vecs.push_back('{1,1,0,1, 32'h100, 32'h080,  32'h100, 1,1,32'h80});
        vecs.push_back('{1,1,0,0, 32'h100, 32'h0,    32'h100, 1,1,32'h80});
        vecs.push_back('{1,1,0,0, 32'h100, 32'h0,    32'h100, 1,1,32'h80});
        vecs.push_back('{0,0,0,0, 32'h000, 32'h0,    32'h100, 1,0,32'h80});
        vecs.push_back('{1,1,0,0, 32'h204, 32'h300,  32'h204, 0,0,32'h0});
        vecs.push_back('{0,0,0,0, 32'h000, 32'h0,    32'h204, 0,0,32'h0});
        vecs.push_back('{1,0,1,0, 32'h040, 32'h1000, 32'h040, 0,0,32'h0});
        vecs.push_back('{1,1,0,0, 32'h040, 32'h044,  32'h040, 1,1,32'h1000});
        vecs.push_back('{0,0,0,0, 32'h000, 32'h0,    32'h040, 1,0,32'h44});
        vecs.push_back('{0,0,0,0, 32'h000, 32'h0,    32'h100, 0,0,32'h0});
        vecs.push_back('{1,1,0,1, 32'h100, 32'h300,  32'h040, 1,0,32'h44});
        vecs.push_back('{1,1,0,1, 32'h120, 32'h500,  32'h100, 1,1,32'h300});
        vecs.push_back('{0,0,0,0, 32'h000, 32'h0,    32'h100, 0,0,32'h0});
        vecs.push_back('{1,0,1,0, 32'h120, 32'h600,  32'h120, 1,1,32'h500});
        vecs.push_back('{1,1,0,0, 32'h100, 32'h0,    32'h120, 1,1,32'h600});
        vecs.push_back('{0,0,0,0, 32'h000, 32'h0,    32'h120, 1,1,32'h600});
        vecs.push_back('{0,0,0,0, 32'h000, 32'h0,    32'h100, 0,0,32'h0});
        vecs.push_back('{1,1,1,1, 32'h204, 32'h9,    32'h204, 0,0,32'h0});
        vecs.push_back('{1,0,0,1, 32'h204, 32'h9,    32'h204, 0,0,32'h0});
        vecs.push_back('{0,1,0,1, 32'h204, 32'h9,    32'h204, 0,0,32'h0});
        vecs.push_back('{0,0,0,0, 32'h000, 32'h0,    32'h204, 0,0,32'h0});

        rst_n = 1'b0; upd_en = 0; upd_branch = 0; upd_jump = 0; upd_taken = 0;
        upd_pc = '0; upd_target = '0; if_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        foreach (vecs[i])
            run_cycle(1'b1, vecs[i].en, vecs[i].br, vecs[i].jp, vecs[i].tk, vecs[i].upc, vecs[i].utg,
                      vecs[i].lpc, vecs[i].ev, vecs[i].et, vecs[i].etg, $sformatf("vec%0d", i));

        // Reset coincident with a jump update: reset wins and history is gone
        run_cycle(1'b0, 1, 0, 1, 1, 32'h208, 32'h700, 32'h120, 1, 1, 32'h600, "rst_pre");
        run_cycle(1'b1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h208, 0, 0, 32'h0,   "rst_upd_dropped");
        run_cycle(1'b1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h120, 0, 0, 32'h0,   "rst_history_lost");

        // Random legal training over a small PC pool so indices alias and hit often
        for (int n = 0; n < 3000; n++) begin
            rn  = ($urandom_range(0, 299) != 0);
            en  = ($urandom_range(0, 3) != 0);
            jp  = ($urandom_range(0, 4) == 0);
            upc = ALEN'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
            lpc = ALEN'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) lpc = upc;
            model_lookup(lpc, ev, et, etg);
            run_cycle(rn, en, !jp, jp, 1'($urandom_range(0, 1)), upc, ALEN'($urandom & 32'hFFFF_FFFE),
                      lpc, ev, et, etg, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
